// File: rtl/set_less_then_32bit.sv
// Registered 32-bit set-less-than (slt/sltu) stage for the ALU.
// Define SLT_SIGNED_EN for signed slt; default build is unsigned sltu.
module set_less_then_32bit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        in_valid,
  output logic [31:0] result,
  output logic        out_valid
);

  logic [31:0] nb;
  logic [32:0] carry;
  logic        cout;
  logic        lt;
  logic        lt_q;

  assign nb       = ~b;
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < 32; i++) begin : g_rip
    assign carry[i+1] = (a[i] & nb[i]) |
                        (carry[i] & (a[i] ^ nb[i]));
  end

  assign cout = carry[32];

`ifdef SLT_SIGNED_EN
  logic diff_msb;
  logic ovf;

  // Only the sign bit of the difference is needed.
  assign diff_msb = a[31] ^ nb[31] ^ carry[31];
  assign ovf      = (a[31] ^ b[31]) & (a[31] ^ diff_msb);
  assign lt       = diff_msb ^ ovf;

  logic unused_cout;
  assign unused_cout = cout;
`else
  assign lt = ~cout;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lt_q      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) lt_q <= lt;
    end
  end

  assign result = {31'b0, lt_q};

endmodule

// File: tb/tb_set_less_then_32bit.sv
// Bench for set_less_then_32bit: directed steps with a scoreboard queue.
// Expected values follow the build (SLT_SIGNED_EN or not).
module tb_set_less_then_32bit;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic        in_valid;
  logic [31:0] result;
  logic        out_valid;

  int errors;
  int checks;

  logic        q[$];
  logic [31:0] last_res;

  set_less_then_32bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .result    (result),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic mdl(
    input logic [31:0] x,
    input logic [31:0] y
  );
`ifdef SLT_SIGNED_EN
    return $signed(x) < $signed(y);
`else
    return x < y;
`endif
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h",
             tag, obs, exp);
    end
  endtask

  task automatic step(
    input logic [31:0] x,
    input logic [31:0] y,
    input logic        v
  );
    logic e;
    a        = x;
    b        = y;
    in_valid = v;
    if (v) q.push_back(mdl(x, y));
    @(posedge clk);
    #1;
    chk("out_valid", {31'b0, out_valid},
        {31'b0, v});
    chk("upper_zero", {1'b0, result[31:1]}, 32'd0);
    if (v) begin
      if (q.size() == 0) begin
        chk("sb_empty", 32'd0, 32'd1);
      end else begin
        e = q.pop_front();
        last_res = {31'b0, e};
        chk("result", result, last_res);
      end
    end else begin
      chk("result_hold", result, last_res);
    end
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    last_res = 32'd0;
    rst_n    = 1'b0;
    a        = 32'd5;
    b        = 32'd9;
    in_valid = 1'b1;

    // Reset state before any clock edge.
    #2;
    chk("rst_result", result, 32'd0);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_hold", result, 32'd0);
    rst_n = 1'b1;

    step(32'd4294000000, 32'd4294000001, 1'b1);
    chk("big_lt", result, 32'd1);
    step(32'd4294000001, 32'd4294000000, 1'b1);
    chk("big_ge", result, 32'd0);
    step(32'd12, 32'd21, 1'b1);
    step(32'd21, 32'd12, 1'b1);
    step(32'd7, 32'd7, 1'b1);
    chk("eq_zero", result, 32'd0);
    step(32'h8000_0000, 32'd1, 1'b1);
`ifdef SLT_SIGNED_EN
    chk("min_vs_1", result, 32'd1);
`else
    chk("min_vs_1", result, 32'd0);
`endif
    step(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1);
`ifdef SLT_SIGNED_EN
    chk("ovf_path", result, 32'd0);
`else
    chk("ovf_path", result, 32'd1);
`endif
    step(32'd0, 32'd1, 1'b1);
    step(32'd9, 32'd3, 1'b0);
    step(32'd1, 32'd0, 1'b0);

    // Back-to-back stream with a reset pulse mid-way.
    step(32'd1, 32'd2, 1'b1);
    step(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_res", result, 32'd0);
    chk("mid_rst_vld", {31'b0, out_valid}, 32'd0);
    q.delete();
    last_res = 32'd0;
    rst_n = 1'b1;
    step(32'd3, 32'd100, 1'b1);
    step(32'hFFFF_FFFF, 32'd0, 1'b1);
    step(32'd0, 32'd0, 1'b0);
    step(32'd5, 32'd6, 1'b0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
